// File: rtl/rvfi_ser_pkg.sv
// Shared types for the RVFI commit serializer: the packed retirement record,
// the event kind, and the FIFO entry that carries either kind of event.
package rvfi_ser_pkg;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic [63:0] pc_rdata;
    logic [63:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [63:0] rd_wdata;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
  } rvfi_rec_t;

  localparam int RVFI_REC_W = $bits(rvfi_rec_t);

  typedef enum logic {
    EV_INSN = 1'b0,
    EV_MIP  = 1'b1
  } ev_kind_e;

  // One buffered event; rec is meaningful for EV_INSN, mip for EV_MIP.
  typedef struct packed {
    ev_kind_e  kind;
    rvfi_rec_t rec;
    logic [31:0] mip;
  } ser_entry_t;

endpackage

// File: rtl/rvfi_ser_mwfifo.sv
// Multi-write, single-read FIFO. Active write lanes are packed into
// consecutive slots starting at the write pointer, lowest lane first, so the
// enqueue order equals lane order. The caller guarantees there is room for
// every asserted lane; this block does not check for overflow.
module rvfi_ser_mwfifo
  import rvfi_ser_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LANES = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES-1:0]        wr_en,
  input  ser_entry_t [LANES-1:0]  wr_data,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output ser_entry_t              rd_data,
  output logic [LW-1:0]           level
);

  ser_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [AW-1:0] slot [LANES];
  logic [LW-1:0] n_wr;
  logic          pop;

  // Prefix count of active lanes gives each lane its slot offset.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    n_wr = '0;
    slot = '{default: '0};
    for (int i = 0; i < LANES; i++) begin
      slot[i] = wr_ptr_q + AW'(n_wr);
      n_wr    = n_wr + LW'(wr_en[i]);
    end
  end

  assign pop = rd_en && (level_q != '0);

  // Storage write; pointers wrap naturally in AW bits.
  // NOTE: the array is not reset; empty-state outputs are masked below instead.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) mem[slot[i]] <= wr_data[i];
    end
  end

  // Pointer and occupancy registers.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(n_wr);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      level_q  <= level_q + n_wr - LW'(pop);
    end
  end

  assign rd_valid = (level_q != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
  assign level    = level_q;

endmodule

// File: rtl/rvfi_commit_serializer.sv
// RVFI commit serializer: turns up to NRET retirements plus mip changes per
// cycle into a single in-order valid/ready event stream for the reference
// model. Within a cycle the mip event goes first, then ports 0..NRET-1.
// A cycle's events are accepted all-or-nothing against pre-pop free space.
// Optional build macro RVFI_SER_ORDER_CHECK_EN enables the rvfi order
// continuity checker; otherwise order_err_o is tied low.
module rvfi_commit_serializer
  import rvfi_ser_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8   // power of two, at least NRET+1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NRET-1:0]              rvfi_valid_i,
  input  logic [NRET*RVFI_REC_W-1:0]   rvfi_rec_i,
  input  logic [31:0]                  mip_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         out_kind_o,
  output logic [RVFI_REC_W-1:0]        out_rec_o,
  output logic [31:0]                  out_mip_o,
  output logic                         overflow_o,
  output logic                         order_err_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int LANES = NRET + 1;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(LANES + 1);

  logic [31:0]            mip_q;
  logic                   overflow_q;
  logic [LANES-1:0]       req;
  logic [LANES-1:0]       wr_en;
  ser_entry_t [LANES-1:0] wr_data;
  logic [CW-1:0]          n_req;
  logic [LW-1:0]          level;
  logic [LW-1:0]          free_slots;
  logic                   accept;
  logic                   head_valid;
  ser_entry_t             head;

  // Lane 0 carries the mip event, lanes 1..NRET the commit ports in order.
  always_comb begin
    req             = '0;
    wr_data         = '0;
    n_req           = '0;
    req[0]          = (mip_i != mip_q);
    wr_data[0].kind = EV_MIP;
    wr_data[0].mip  = mip_i;
    for (int p = 0; p < NRET; p++) begin
      req[p+1]          = rvfi_valid_i[p];
      wr_data[p+1].kind = EV_INSN;
      wr_data[p+1].rec  = rvfi_rec_i[p*RVFI_REC_W +: RVFI_REC_W];
    end
    for (int i = 0; i < LANES; i++) begin
      n_req = n_req + CW'(req[i]);
    end
  end

  // Space check uses occupancy before any same-cycle pop.
  assign free_slots = LW'(DEPTH) - level;
  assign accept     = (free_slots >= LW'(n_req));
  assign wr_en      = accept ? req : '0;

  rvfi_ser_mwfifo #(
    .DEPTH (DEPTH),
    .LANES (LANES)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (out_ready_i),
    .rd_valid (head_valid),
    .rd_data  (head),
    .level    (level)
  );

  // Last enqueued mip value; a dropped mip event leaves it unchanged so it retries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mip_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en[0]) mip_q <= mip_i;
      if (!accept && (n_req != '0)) overflow_q <= 1'b1;
    end
  end

`ifdef RVFI_SER_ORDER_CHECK_EN
  logic [63:0] exp_order_q;
  logic [63:0] exp_order_d;
  logic        order_seen_q;
  logic        order_seen_d;
  logic        order_err_q;
  logic        order_hit;

  // Walk accepted instruction events in enqueue order, chaining the expectation.
  always_comb begin
    exp_order_d  = exp_order_q;
    order_seen_d = order_seen_q;
    order_hit    = 1'b0;
    for (int p = 0; p < NRET; p++) begin
      if (wr_en[p+1]) begin
        if (order_seen_d && (wr_data[p+1].rec.order != exp_order_d)) order_hit = 1'b1;
        exp_order_d  = wr_data[p+1].rec.order + 64'd1;
        order_seen_d = 1'b1;
      end
    end
  end

  // Expected-order state and the sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_order_q  <= '0;
      order_seen_q <= 1'b0;
      order_err_q  <= 1'b0;
    end else begin
      exp_order_q  <= exp_order_d;
      order_seen_q <= order_seen_d;
      if (order_hit) order_err_q <= 1'b1;
    end
  end

  assign order_err_o = order_err_q;
`else
  assign order_err_o = 1'b0;
`endif

  assign out_valid_o = head_valid;
  assign out_kind_o  = head.kind;
  assign out_rec_o   = head.rec;
  assign out_mip_o   = head.mip;
  assign overflow_o  = overflow_q;
  assign level_o     = level;

endmodule
